store_fwd_buffer: RTL

STORE_FWD_BUFFER -- requirements
Module: store_fwd_buffer

---
 rtl/store_fwd_buffer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/store_fwd_buffer.sv
// Committed-store buffer: FIFO of word-aligned stores drained to SRAM, with per-lane load forwarding.
// Optional STB_COALESCE_EN merges a store into the youngest entry on a word-address match.
module store_fwd_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_wdata,
  input  logic [DATA_W/8-1:0]        st_wstrb,
  output logic                       mem_req,
  input  logic                       mem_ack,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [DATA_W/8-1:0]        mem_wstrb,
  input  logic [ADDR_W-1:0]          ld_addr,
  input  logic [2:0]                 ld_op,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic [DATA_W-1:0]          ld_data,
  output logic                       ld_excp_ale,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int BW  = DATA_W / 8;
  localparam int OFF = $clog2(BW);
  localparam int PW  = $clog2(DEPTH);
  localparam int WA  = ADDR_W - OFF;
  localparam logic [OFF-1:0] M_H = ~OFF'(1);
  localparam logic [OFF-1:0] M_W = ~OFF'(3);

  logic [WA-1:0]     r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [BW-1:0]     r_strb [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PW-1:0]     r_head, r_tail;
  logic [PW:0]       r_count;

  logic [WA-1:0]     w_st_wa, w_ld_wa;
  logic              w_pop, w_push, w_coal;
  logic              w_unused;

  assign w_st_wa  = st_addr[ADDR_W-1:OFF];
  assign w_ld_wa  = ld_addr[ADDR_W-1:OFF];
  assign w_unused = ^st_addr[OFF-1:0];

  assign count     = r_count;
  assign full      = (r_count == (PW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign mem_req   = !empty;
  assign mem_addr  = {r_addr[r_head], {OFF{1'b0}}};
  assign mem_wdata = r_data[r_head];
  assign mem_wstrb = empty ? '0 : r_strb[r_head];
  assign w_pop     = mem_req && mem_ack;

`ifdef STB_COALESCE_EN
  logic [PW-1:0] w_young;
  assign w_young = r_tail - PW'(1);
  // The sole/head entry may still absorb bytes while its drain is not being acked this cycle.
  assign w_coal  = !empty && (r_addr[w_young] == w_st_wa) && !((w_young == r_head) && w_pop);
`else
  assign w_coal  = 1'b0;
`endif

  assign st_ready = !full || w_coal;
  assign w_push   = st_valid && st_ready && !w_coal;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_push) begin
        r_addr[r_tail] <= w_st_wa;
        r_data[r_tail] <= st_wdata;
        r_strb[r_tail] <= st_wstrb;
        r_vld[r_tail]  <= 1'b1;
        r_tail         <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PW'(1);
      end
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_push && w_pop)
        r_count <= r_count - 1'b1;
`ifdef STB_COALESCE_EN
      if (st_valid && w_coal) begin
        for (int b = 0; b < BW; b++)
          if (st_wstrb[b]) r_data[w_young][8*b +: 8] <= st_wdata[8*b +: 8];
        r_strb[w_young] <= r_strb[w_young] | st_wstrb;
      end
`endif
    end
  end

  // Walk oldest to youngest so the youngest matching lane wins.
  logic [DATA_W-1:0] w_merged;
  logic [PW-1:0]     w_idx;
  always_comb begin
    w_merged = mem_rdata;
    w_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if (r_vld[w_idx] && (r_addr[w_idx] == w_ld_wa))
        for (int b = 0; b < BW; b++)
          if (r_strb[w_idx][b]) w_merged[8*b +: 8] = r_data[w_idx][8*b +: 8];
    end
  end

  logic [OFF-1:0]    w_off;
  logic [DATA_W-1:0] w_sh_b, w_sh_h, w_sh_w, w_res;
  logic              w_ale;
  always_comb begin
    w_off  = ld_addr[OFF-1:0];
    w_sh_b = w_merged >> {w_off, 3'b000};
    w_sh_h = w_merged >> {w_off & M_H, 3'b000};
    w_sh_w = w_merged >> {w_off & M_W, 3'b000};
    w_ale  = 1'b0;
    w_res  = DATA_W'(w_sh_w[31:0]);
    case (ld_op)
      3'b000: w_res = DATA_W'($signed(w_sh_b[7:0]));
      3'b100: w_res = DATA_W'(w_sh_b[7:0]);
      3'b001: begin
        w_ale = w_off[0];
        w_res = DATA_W'($signed(w_sh_h[15:0]));
      end
      3'b101: begin
        w_ale = w_off[0];
        w_res = DATA_W'(w_sh_h[15:0]);
      end
      3'b010: begin
        w_ale = (w_off[1:0] != 2'b00);
        w_res = DATA_W'($signed(w_sh_w[31:0]));
      end
      3'b011: begin
        if (DATA_W == 64) begin
          w_ale = (w_off != '0);
          w_res = w_merged;
        end
      end
      default: w_res = DATA_W'(w_sh_w[31:0]);
    endcase
  end

  assign ld_excp_ale = w_ale;
  assign ld_data     = w_ale ? '0 : w_res;

endmodule
